// File: rtl/pipeline_fetch_unit.sv
// ---------------------------------------------------------------------------
// pipeline_fetch_unit
//
// Instruction fetch front end for the 4-stage pipeline_processor datapath.
// Holds the instruction memory, the program counter and a small prefetch
// FIFO, and hands {pc, instruction} pairs to decode over valid/ready.
// Execute may redirect the fetch stream, which discards every prefetched
// entry and restarts fetching at the new PC.
//
// Optional feature macro: FETCH_HALT_DETECT_EN
//   defined   : a fetched opcode 4'b1111 stops fetching (RUN -> HALT).
//   undefined : opcode 4'b1111 is an ordinary instruction; HALT is never
//               entered and `halted` is tied low.
//
// Parameters
//   DEPTH    prefetch FIFO entries (power of two, 2..8)
//   PC_W     PC width; instruction memory holds 2**PC_W words
//   INSTR_W  instruction width; opcode is bits [INSTR_W-1 -: 4]
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   start           one-cycle pulse, IDLE -> RUN, fetch begins at PC 0
//   prog_we         instruction memory write enable (IDLE/HALT only)
//   prog_addr       instruction memory write address
//   prog_data       instruction memory write data
//   redirect_valid  flush prefetched entries and continue at redirect_pc
//   redirect_pc     redirect target PC
//   out_valid       FIFO head holds a valid instruction
//   out_ready       decode accepts the head this cycle
//   out_instr       instruction at the FIFO head (0 when empty)
//   out_pc          PC of the FIFO head (0 when empty)
//   busy            state is RUN
//   halted          state is HALT
// ---------------------------------------------------------------------------
module pipeline_fetch_unit #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 4,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               busy,
  output logic               halted
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int MEM_WORDS = 1 << PC_W;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

`ifdef FETCH_HALT_DETECT_EN
  localparam logic [3:0] OPC_HALT = 4'b1111;
`endif

  // Control state
  logic [1:0]       state_q,  state_d;
  logic [PC_W-1:0]  pc_q,     pc_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  // Storage: instruction memory and FIFO payload are never reset; the
  // FIFO count alone decides which payload slots are meaningful.
  logic [INSTR_W-1:0] imem_q       [MEM_WORDS];
  logic [INSTR_W-1:0] fifo_instr_q [DEPTH];
  logic [PC_W-1:0]    fifo_pc_q    [DEPTH];

  logic               redirect_en;
  logic               pop;
  logic               push;
  logic               fetch_ok;
  logic               halt_hit;
  logic               imem_we;
  logic [INSTR_W-1:0] fetch_instr;

  // -------------------------------------------------------------------------
  // Handshake and fetch decisions
  // -------------------------------------------------------------------------
  always_comb begin
    // A redirect only means something once fetching has been started.
    redirect_en = redirect_valid && (state_q != ST_IDLE);
    pop         = out_valid && out_ready;
    // A full FIFO may still accept a word when the head leaves this cycle.
    fetch_ok    = (count_q < DEPTH_CNT) || pop;
    push        = (state_q == ST_RUN) && fetch_ok && !redirect_en;
    fetch_instr = imem_q[pc_q];
    imem_we     = prog_we && (state_q != ST_RUN);
`ifdef FETCH_HALT_DETECT_EN
    halt_hit    = push && (fetch_instr[INSTR_W-1 -: 4] == OPC_HALT);
`else
    halt_hit    = 1'b0;
`endif
  end

  // -------------------------------------------------------------------------
  // Next-state: FSM, PC, FIFO pointers and occupancy
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        if (redirect_en) begin
          pc_d = redirect_pc;
        end else if (halt_hit) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (redirect_en) begin
          state_d = ST_RUN;
          pc_d    = redirect_pc;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (redirect_en) begin
      // Flush overrides any pop or push requested in the same cycle.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        // The halt instruction is still pushed and the PC moves past it.
        pc_d     = pc_q + PC_W'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Instruction memory (program load only outside RUN)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_q[prog_addr] <= prog_data;
    end
  end

  // -------------------------------------------------------------------------
  // Prefetch FIFO payload
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= fetch_instr;
      fifo_pc_q[wr_ptr_q]    <= pc_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid = (count_q != '0);
    out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
    out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : '0;
    busy      = (state_q == ST_RUN);
`ifdef FETCH_HALT_DETECT_EN
    halted    = (state_q == ST_HALT);
`else
    halted    = 1'b0;
`endif
  end

endmodule

// File: doc/pipeline_fetch_unit.md
# pipeline_fetch_unit

Instruction fetch front end for the 4-stage `pipeline_processor` datapath. It owns the 16-entry instruction memory, the program counter and a small prefetch FIFO, and delivers `{pc, instruction}` pairs to the decode stage over a valid/ready handshake. The decode stage applies backpressure through the handshake, and execute can redirect the fetch stream, which flushes everything prefetched.

## Interface
Parameters:
- `DEPTH`, 4: prefetch FIFO entries; power of two, 2..8.
- `PC_W`, 4: PC width; instruction memory holds 2^PC_W words.
- `INSTR_W`, 16: instruction width; opcode is bits [INSTR_W-1 -: 4].

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; leaves IDLE and begins fetching at PC 0.
- `prog_we`  in  1  instruction memory write enable.
- `prog_addr`  in  PC_W  instruction memory write address.
- `prog_data`  in  INSTR_W  instruction memory write data.
- `redirect_valid`  in  1  flush request with a new PC.
- `redirect_pc`  in  PC_W  target PC for the redirect.
- `out_valid`  out  1  FIFO head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  INSTR_W  instruction at the FIFO head.
- `out_pc`  out  PC_W  PC of the FIFO head.
- `busy`  out  1  state is RUN.
- `halted`  out  1  state is HALT.

## Operation
- State machine: IDLE, RUN, HALT.
  - IDLE -> RUN on `start`; PC <= 0.
  - RUN -> HALT per Configuration.
  - HALT -> RUN on `redirect_valid`.
  - `start` outside IDLE is ignored.
- Fetch: in RUN, when `fetch_ok = (count < DEPTH) || pop`, the word `imem[pc]` and `pc` are pushed into the FIFO and `pc` increments, wrapping from 2^PC_W-1 to 0. In IDLE and HALT nothing is pushed.
- Pop: a pop occurs when `out_valid && out_ready`. Push and pop in the same cycle keep `count` unchanged, including when the FIFO is full.
- Redirect:
  - In RUN or HALT, the FIFO is cleared (count 0, pointers 0), `pc <= redirect_pc`, and no push occurs that cycle.
  - Redirect wins over a simultaneous pop or push, and over a simultaneous `start`.
  - Redirect in IDLE is ignored.
- Program load: `prog_we` writes `imem[prog_addr]` only in IDLE or HALT; it is ignored in RUN. Memory contents are not cleared by reset.
- `out_instr` and `out_pc` are driven from the FIFO head storage. They are 0 when empty.

## Timing
- Reset values: state IDLE, `pc` 0, `count` 0, `out_valid` 0, `out_instr` 0, `out_pc` 0, `busy` 0, `halted` 0.
- Reset is asserted asynchronously and released synchronously to `clk` by the top level. Reset asserted mid-fetch drops all FIFO contents immediately.
- Latency:
  - `start` sampled at edge N: `busy` goes high after N.
  - The first push happens at edge N+1, so `out_valid` goes high after N+1.
- Memory read is combinational within the fetch cycle. A `prog_data` write at edge N is fetchable from edge N+1.
- Throughput: one instruction per cycle with `out_ready` held high.
- Redirect at edge N: `out_valid` is low after N, and the instruction at `redirect_pc` is visible after N+1.
- Handshake rule: once `out_valid` is high, `out_instr` and `out_pc` stay stable until a pop or a redirect.

## Configuration
- `FETCH_HALT_DETECT_EN` defined:
  - A pushed instruction with opcode 4'b1111 moves the state RUN -> HALT on the same edge.
  - The halt instruction itself is still delivered downstream, and the PC is left pointing past it.
  - `halted` rises after that edge.
- `FETCH_HALT_DETECT_EN` undefined:
  - Opcode 4'b1111 is fetched like any other instruction.
  - HALT is unreachable, `halted` is tied to 0, and fetch runs until a redirect or reset.

## Test plan
- Reset, load imem[0..3] = 16'h1123, 16'h2412, 16'h3509, 16'h6655; pulse `start` with `out_ready`=1 -> `out_pc` 0,1,2,3 on consecutive cycles with the matching instructions, first `out_valid` two edges after `start`.
- Hold `out_ready`=0 after `start` -> `count` saturates at DEPTH=4 (PCs 0..3 held), head stays 0/16'h1123. Release `out_ready` -> pops continue in order with no gap or duplicate.
- Redirect to PC 9 while full and popping -> FIFO flushed, `out_valid` low for one cycle, next head `out_pc`=9 with `imem[9]`.
- Run past PC 15 with `out_ready`=1 -> `out_pc` sequence 14, 15, 0, 1.
- With `FETCH_HALT_DETECT_EN`, imem[2] = 16'hF000 -> PCs 0,1,2 delivered, `halted`=1, `busy`=0, no further pushes. `prog_we` now writes; redirect to 0 resumes. Without the macro, fetch continues to PC 3.
- Assert `reset` low mid-run with 3 entries queued -> `out_valid`, `busy`, `halted` are 0 immediately; `prog_we` during RUN leaves imem unchanged.
